// File: rtl/ili9341_spi_target_pkg.sv
// Shared definitions for the ILI9341 SPI target: command codes, pixel type,
// decode FSM states and the window validity rule.
package ili9341_spi_target_pkg;

    localparam int unsigned BYTE_BITS = 8;

    localparam logic [7:0] CMD_NOP   = 8'h00;
    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    typedef logic [15:0] ili9341_color_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CASET,
        S_PASET,
        S_PIX_HI,
        S_PIX_LO,
        S_IGNORE
    } state_t;

    // A window is accepted only if it is ordered and ends inside the panel.
    function automatic logic window_ok(input logic [15:0] start_v,
                                       input logic [15:0] end_v,
                                       input logic [15:0] limit);
        return (start_v <= end_v) && (end_v < limit);
    endfunction

endpackage

// File: rtl/ili9341_spi_target_deserializer.sv
// SPI mode-0 front end: synchronises the link into clk, assembles MSB-first bytes
// and flags bytes cut short by chip-select rising.
module ili9341_spi_target_deserializer
    import ili9341_spi_target_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       soft_rstb,
    input  logic       spi_csb,
    input  logic       spi_clk,
    input  logic       spi_mosi,
    input  logic       data_commandb,
    output logic       byte_done,
    output logic [7:0] byte_data,
    output logic       byte_dcx,
    output logic       partial_err
);

    logic [SYNC_STAGES-1:0] csb_sync_q, csb_sync_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] dcx_sync_q, dcx_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [6:0]             byte_sr_q, byte_sr_d;
    logic [7:0]             byte_data_q, byte_data_d;
    logic                   byte_done_q, byte_done_d;
    logic                   byte_dcx_q, byte_dcx_d;
    logic                   partial_err_q, partial_err_d;

    logic csb_s, sclk_s, mosi_s, dcx_s, sclk_rise;

    assign csb_s     = csb_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign dcx_s     = dcx_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;

    always_comb begin
        // NOTE: every _d starts from its _q (or its idle value) so no path through this block infers a latch.
        csb_sync_d    = {csb_sync_q[SYNC_STAGES-2:0], spi_csb};
        sclk_sync_d   = {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
        mosi_sync_d   = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        dcx_sync_d    = {dcx_sync_q[SYNC_STAGES-2:0], data_commandb};
        sclk_prev_d   = sclk_s;
        bit_cnt_d     = bit_cnt_q;
        byte_sr_d     = byte_sr_q;
        byte_data_d   = byte_data_q;
        byte_dcx_d    = byte_dcx_q;
        byte_done_d   = 1'b0;
        partial_err_d = 1'b0;

        if (csb_s) begin
            bit_cnt_d     = '0;
            partial_err_d = (bit_cnt_q != '0);
        end else if (sclk_rise) begin
            byte_sr_d = {byte_sr_q[5:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'(BYTE_BITS - 1)) begin
                byte_done_d = 1'b1;
                byte_data_d = {byte_sr_q, mosi_s};
                byte_dcx_d  = dcx_s;
            end
        end
    end

    // NOTE: synchronous reset -- the reset input is only looked at inside the clocked block.
    always_ff @(posedge clk) begin
        if (!rst || !soft_rstb) begin
            csb_sync_q    <= '1;
            sclk_sync_q   <= '0;
            mosi_sync_q   <= '0;
            dcx_sync_q    <= '0;
            sclk_prev_q   <= 1'b0;
            bit_cnt_q     <= '0;
            byte_sr_q     <= '0;
            byte_data_q   <= '0;
            byte_done_q   <= 1'b0;
            byte_dcx_q    <= 1'b0;
            partial_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            csb_sync_q    <= csb_sync_d;
            sclk_sync_q   <= sclk_sync_d;
            mosi_sync_q   <= mosi_sync_d;
            dcx_sync_q    <= dcx_sync_d;
            sclk_prev_q   <= sclk_prev_d;
            bit_cnt_q     <= bit_cnt_d;
            byte_sr_q     <= byte_sr_d;
            byte_data_q   <= byte_data_d;
            byte_done_q   <= byte_done_d;
            byte_dcx_q    <= byte_dcx_d;
            partial_err_q <= partial_err_d;
        end
    end

    assign byte_done   = byte_done_q;
    assign byte_data   = byte_data_q;
    assign byte_dcx    = byte_dcx_q;
    assign partial_err = partial_err_q;

endmodule

// File: rtl/ili9341_spi_target.sv
// ILI9341 panel stand-in: decodes CASET/PASET/RAMWR from the SPI byte stream and
// emits one addressed RGB565 pixel write per received pixel.
module ili9341_spi_target
    import ili9341_spi_target_pkg::*;
#(
    parameter int DISPLAY_WIDTH  = 240,
    parameter int DISPLAY_HEIGHT = 320,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              display_rstb,
    input  logic                              spi_csb,
    input  logic                              spi_clk,
    input  logic                              spi_mosi,
    input  logic                              data_commandb,
    output logic                              pixel_valid,
    output logic [$clog2(DISPLAY_WIDTH):0]    pixel_x,
    output logic [$clog2(DISPLAY_HEIGHT):0]   pixel_y,
    output logic [15:0]                       pixel_color,
    output logic                              frame_done,
    output logic                              cmd_valid,
    output logic [7:0]                        cmd_byte,
    output logic                              proto_error
);

    localparam int XW = $clog2(DISPLAY_WIDTH) + 1;
    localparam int YW = $clog2(DISPLAY_HEIGHT) + 1;

    logic       byte_done, byte_dcx, partial_err;
    logic [7:0] byte_data;

    ili9341_spi_target_deserializer #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_deser (
        .clk           (clk),
        .rst           (rst),
        .soft_rstb     (display_rstb),
        .spi_csb       (spi_csb),
        .spi_clk       (spi_clk),
        .spi_mosi      (spi_mosi),
        .data_commandb (data_commandb),
        .byte_done     (byte_done),
        .byte_data     (byte_data),
        .byte_dcx      (byte_dcx),
        .partial_err   (partial_err)
    );

    state_t         state_q, state_d;
    logic [1:0]     arg_cnt_q, arg_cnt_d;
    logic [23:0]    arg_q, arg_d;
    logic [XW-1:0]  x_start_q, x_start_d, x_end_q, x_end_d, cur_x_q, cur_x_d;
    logic [YW-1:0]  y_start_q, y_start_d, y_end_q, y_end_d, cur_y_q, cur_y_d;
    logic [7:0]     pix_hi_q, pix_hi_d;
    logic           pixel_valid_q, pixel_valid_d;
    logic [XW-1:0]  pixel_x_q, pixel_x_d;
    logic [YW-1:0]  pixel_y_q, pixel_y_d;
    ili9341_color_t pixel_color_q, pixel_color_d;
    logic           frame_done_q, frame_done_d;
    logic           cmd_valid_q, cmd_valid_d;
    logic [7:0]     cmd_byte_q, cmd_byte_d;
    logic           proto_error_q, proto_error_d;

    // Window arguments arrive start_hi, start_lo, end_hi, end_lo; the last one is still on byte_data.
    logic [15:0] arg_start, arg_end;
    assign arg_start = arg_q[23:8];
    assign arg_end   = {arg_q[7:0], byte_data};

    always_comb begin
        state_d       = state_q;
        arg_cnt_d     = arg_cnt_q;
        arg_d         = arg_q;
        x_start_d     = x_start_q;
        x_end_d       = x_end_q;
        y_start_d     = y_start_q;
        y_end_d       = y_end_q;
        cur_x_d       = cur_x_q;
        cur_y_d       = cur_y_q;
        pix_hi_d      = pix_hi_q;
        pixel_x_d     = pixel_x_q;
        pixel_y_d     = pixel_y_q;
        pixel_color_d = pixel_color_q;
        cmd_byte_d    = cmd_byte_q;
        pixel_valid_d = 1'b0;
        frame_done_d  = 1'b0;
        cmd_valid_d   = 1'b0;
        proto_error_d = proto_error_q | partial_err;

        if (byte_done && !byte_dcx) begin
            // Commands abort whatever was in progress, including a half pixel.
            cmd_valid_d = 1'b1;
            cmd_byte_d  = byte_data;
            arg_cnt_d   = '0;
            case (byte_data)
                CMD_CASET: state_d = S_CASET;
                CMD_PASET: state_d = S_PASET;
                CMD_RAMWR: begin
                    cur_x_d = x_start_q;
                    cur_y_d = y_start_q;
                    state_d = S_PIX_HI;
                end
                default:   state_d = S_IGNORE;
            endcase
        end else if (byte_done) begin
            case (state_q)
                S_CASET, S_PASET: begin
                    arg_d     = {arg_q[15:0], byte_data};
                    arg_cnt_d = arg_cnt_q + 2'd1;
                    if (arg_cnt_q == 2'd3) begin
                        state_d = S_IGNORE;
                        if (state_q == S_CASET) begin
                            if (window_ok(arg_start, arg_end, 16'(DISPLAY_WIDTH))) begin
                                x_start_d = arg_start[XW-1:0];
                                x_end_d   = arg_end[XW-1:0];
                            end else begin
                                proto_error_d = 1'b1;
                            end
                        end else begin
                            if (window_ok(arg_start, arg_end, 16'(DISPLAY_HEIGHT))) begin
                                y_start_d = arg_start[YW-1:0];
                                y_end_d   = arg_end[YW-1:0];
                            end else begin
                                proto_error_d = 1'b1;
                            end
                        end
                    end
                end
                S_PIX_HI: begin
                    pix_hi_d = byte_data;
                    state_d  = S_PIX_LO;
                end
                S_PIX_LO: begin
                    pixel_valid_d = 1'b1;
                    pixel_x_d     = cur_x_q;
                    pixel_y_d     = cur_y_q;
                    pixel_color_d = {pix_hi_q, byte_data};
                    frame_done_d  = (cur_x_q == x_end_q) && (cur_y_q == y_end_q);
                    state_d       = S_PIX_HI;
                    if (cur_x_q < x_end_q) begin
                        cur_x_d = cur_x_q + XW'(1);
                    end else begin
                        cur_x_d = x_start_q;
                        cur_y_d = (cur_y_q < y_end_q) ? cur_y_q + YW'(1) : y_start_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || !display_rstb) begin
            state_q       <= S_IDLE;
            arg_cnt_q     <= '0;
            arg_q         <= '0;
            x_start_q     <= '0;
            x_end_q       <= XW'(DISPLAY_WIDTH - 1);
            y_start_q     <= '0;
            y_end_q       <= YW'(DISPLAY_HEIGHT - 1);
            cur_x_q       <= '0;
            cur_y_q       <= '0;
            pix_hi_q      <= '0;
            pixel_valid_q <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            pixel_color_q <= '0;
            frame_done_q  <= 1'b0;
            cmd_valid_q   <= 1'b0;
            cmd_byte_q    <= CMD_NOP;
            proto_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            arg_cnt_q     <= arg_cnt_d;
            arg_q         <= arg_d;
            x_start_q     <= x_start_d;
            x_end_q       <= x_end_d;
            y_start_q     <= y_start_d;
            y_end_q       <= y_end_d;
            cur_x_q       <= cur_x_d;
            cur_y_q       <= cur_y_d;
            pix_hi_q      <= pix_hi_d;
            pixel_valid_q <= pixel_valid_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            pixel_color_q <= pixel_color_d;
            frame_done_q  <= frame_done_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_byte_q    <= cmd_byte_d;
            proto_error_q <= proto_error_d;
        end
    end

    assign pixel_valid = pixel_valid_q;
    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign pixel_color = pixel_color_q;
    assign frame_done  = frame_done_q;
    assign cmd_valid   = cmd_valid_q;
    assign cmd_byte    = cmd_byte_q;
    assign proto_error = proto_error_q;

endmodule
